// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
// Size and FSM state encodings, latency ceiling, and load extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int unsigned MAX_LATENCY = 15;

    // Sign- or zero-extend a right-aligned load result to 32 bits.
    function automatic logic [31:0] extend(input logic [31:0] raw, input size_e size,
                                           input logic is_unsigned);
        case (size)
            SZ_BYTE: extend = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SZ_HALF: extend = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            SZ_WORD: extend = raw;
            default: extend = '0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input size_e size);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001;
            SZ_HALF: lane_mask = 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Four-bank byte RAM. Access byte i lives at address addr+i (mod capacity); each
// bank rotates its row/lane so any alignment, including wrap-around, is one access.
module dmem_byte_array #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wmask,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

    logic [7:0] bank_rdata [4];

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [1:0]        lane;
        logic              carry;
        logic [ADDR_W-3:0] row;
        logic [7:0]        mem [DEPTH];

        // Bank b holds access byte (b - addr[1:0]) mod 4; it sits one row up
        // when that byte crossed a word boundary.
        assign lane  = 2'(b) - addr[1:0];
        assign carry = (2'(b) < addr[1:0]);
        assign row   = addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, carry};

        // NOTE: storage has no reset; contents are undefined until written.
        always_ff @(posedge clk) begin
            if (wmask[lane]) begin
                mem[row] <= wdata[8*lane +: 8];
            end
        end

        assign bank_rdata[b] = mem[row];
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[8*i +: 8] = bank_rdata[2'(i) + addr[1:0]];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: valid/ready request/response, configurable wait states,
// sub-word loads with extension. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] LAT = (LATENCY > MAX_LATENCY) ? 4'(MAX_LATENCY) : 4'(LATENCY);

    state_e      state, state_next;
    logic [3:0]  cnt, cnt_next;
    size_e       size;
    logic        accept;
    logic        fault;
    logic [3:0]  wmask;
    logic [31:0] arr_rdata;

    assign size      = size_e'(req_size);
    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((size == SZ_HALF) && req_addr[0]) ||
                        ((size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign fault      = (size == SZ_ILL) || misaligned;
`else
    assign fault      = (size == SZ_ILL);
`endif

    // Stores commit at the accept edge; faulting requests never write.
    assign wmask = (accept && req_we && !fault) ? lane_mask(size) : 4'b0000;

    dmem_byte_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .addr  (req_addr),
        .wmask (wmask),
        .wdata (req_wdata),
        .rdata (arr_rdata)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_next   = LAT;
                    state_next = (LAT != 4'd0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    cnt_next   = '0;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // rsp_valid rises on the first edge spent in RESP, giving accept-to-valid of LATENCY+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                rsp_rdata <= (req_we || fault) ? 32'h0 : extend(arr_rdata, size, req_unsigned);
                rsp_err   <= fault;
            end
            if (state == S_RESP && !rsp_valid) begin
                rsp_valid <= 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (ADDR_W=12, LATENCY=3); expectations follow
// DMEM_MISALIGN_TRAP_EN when the macro is defined for the build.
module tb_data_mem_ctrl;

    localparam int ADDR_W  = 12;
    localparam int LATENCY = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int checks   = 0;
    int failures = 0;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // One full transaction with rsp_ready held high; lat = edges from accept to rsp_valid.
    task automatic xact(input logic we, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        rsp_ready    = 1'b1;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
            if (rsp_valid) break;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; req_we = 1'b0;
        req_addr = '0; req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 12'h010, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL store_word_rsp got=%h/%b exp=00000000/0", rd, er); end
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL store_latency got=%0d exp=%0d", lat, LATENCY + 1); end
        xact(1'b0, 12'h010, 2'd2, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL load_word got=%h/%b exp=deadbeef/0", rd, er); end
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL load_latency got=%0d exp=%0d", lat, LATENCY + 1); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 12'h013, 2'd0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFDE) begin failures++; $display("FAIL byte_signed got=%h exp=ffffffde", rd); end
        xact(1'b0, 12'h013, 2'd0, 1'b1, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h000000DE) begin failures++; $display("FAIL byte_unsigned got=%h exp=000000de", rd); end
        xact(1'b0, 12'h012, 2'd1, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFDEAD) begin failures++; $display("FAIL half_signed got=%h exp=ffffdead", rd); end
        xact(1'b0, 12'h010, 2'd1, 1'b1, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0000BEEF) begin failures++; $display("FAIL half_unsigned got=%h exp=0000beef", rd); end
        xact(1'b0, 12'h011, 2'd0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFBE) begin failures++; $display("FAIL byte_signed_lane1 got=%h exp=ffffffbe", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; logic ready_low; logic stable;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
        req_addr = 12'h010; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; ready_low = 1'b1;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
            if (req_ready !== 1'b0) ready_low = 1'b0;
            if (rsp_valid) break;
        end
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LATENCY + 1); end
        checks++; if (ready_low !== 1'b1) begin failures++; $display("FAIL bp_ready_busy got=%b exp=1", ready_low); end
        // A store presented while busy must be ignored.
        req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0; req_size = 2'd2;
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_hold got=%b exp=1", stable); end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_dequeue got=%b/%b exp=0/1", rsp_valid, req_ready); end
        xact(1'b0, 12'h010, 2'd2, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_no_stray_write got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 12'h000, 2'd2, 1'b0, 32'h03020100, rd, er, lat);
        xact(1'b1, 12'h004, 2'd2, 1'b0, 32'h07060504, rd, er, lat);
        xact(1'b1, 12'h003, 2'd2, 1'b0, 32'h11223344, rd, er, lat);
        checks++; if (er !== TRAP || rd !== 32'h0) begin failures++; $display("FAIL mis_store_rsp got=%b/%h exp=%b/00000000", er, rd, TRAP); end
        xact(1'b0, 12'h003, 2'd0, 1'b1, 32'h0, rd, er, lat);
        checks++; if (rd !== (TRAP ? 32'h03 : 32'h44)) begin failures++; $display("FAIL mis_byte3 got=%h exp=%h", rd, TRAP ? 32'h03 : 32'h44); end
        xact(1'b0, 12'h006, 2'd0, 1'b1, 32'h0, rd, er, lat);
        checks++; if (rd !== (TRAP ? 32'h06 : 32'h11)) begin failures++; $display("FAIL mis_byte6 got=%h exp=%h", rd, TRAP ? 32'h06 : 32'h11); end
        xact(1'b0, 12'h004, 2'd2, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== (TRAP ? 32'h07060504 : 32'h07112233)) begin failures++; $display("FAIL mis_word4 got=%h exp=%h", rd, TRAP ? 32'h07060504 : 32'h07112233); end
        xact(1'b0, 12'h005, 2'd1, 1'b1, 32'h0, rd, er, lat);
        checks++; if (er !== TRAP || rd !== (TRAP ? 32'h0 : 32'h00001122)) begin failures++; $display("FAIL mis_half5 got=%b/%h exp=%b/%h", er, rd, TRAP, TRAP ? 32'h0 : 32'h00001122); end
    endtask

    task automatic test_illegal_wrap();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 12'h020, 2'd2, 1'b0, 32'h55667788, rd, er, lat);
        xact(1'b1, 12'h020, 2'd3, 1'b0, 32'hAAAAAAAA, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL ill_store_rsp got=%b/%h exp=1/00000000", er, rd); end
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL ill_latency got=%0d exp=%0d", lat, LATENCY + 1); end
        xact(1'b0, 12'h020, 2'd2, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h55667788 || er !== 1'b0) begin failures++; $display("FAIL ill_mem_kept got=%h/%b exp=55667788/0", rd, er); end
        xact(1'b0, 12'h020, 2'd3, 1'b0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL ill_load_rsp got=%b/%h exp=1/00000000", er, rd); end
        xact(1'b1, 12'hFFE, 2'd2, 1'b0, 32'hCAFEF00D, rd, er, lat);
        checks++; if (er !== TRAP) begin failures++; $display("FAIL wrap_store_err got=%b exp=%b", er, TRAP); end
        xact(1'b0, 12'h000, 2'd0, 1'b1, 32'h0, rd, er, lat);
        checks++; if (rd !== (TRAP ? 32'h00 : 32'hFE)) begin failures++; $display("FAIL wrap_byte0 got=%h exp=%h", rd, TRAP ? 32'h00 : 32'hFE); end
        xact(1'b0, 12'h001, 2'd0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== (TRAP ? 32'h01 : 32'hFFFFFFCA)) begin failures++; $display("FAIL wrap_byte1 got=%h exp=%h", rd, TRAP ? 32'h01 : 32'hFFFFFFCA); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; logic stale;
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1;
        req_addr = 12'h030; req_size = 2'd2; req_wdata = 32'h0BADF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", req_ready); end
        @(negedge clk) rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_now got=%b/%b exp=0/1", rsp_valid, req_ready); end
        @(negedge clk) rst_n = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0) begin failures++; $display("FAIL mid_stale_rsp got=%b exp=0", stale); end
        xact(1'b0, 12'h030, 2'd2, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin failures++; $display("FAIL mid_store_kept got=%h/%b exp=0badf00d/0", rd, er); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_backpressure();
        test_misalign();
        test_illegal_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
